audio_sequencer: RTL
====================

# audio_sequencer

Sequences the audio PWM path from game events. A one-cycle `act_sonido` request with an 8-bit sound code plays a stored pattern of up to four notes with per-note duration and fixed inter-note gaps. The block drives the tone half-period and enable into the PWM generator inside `empaquetado_audio`. It buffers one pending request while a pattern is playing and supports immediate abort.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; sets the ms tick and the note half-periods.
- `GAP_MS`, 10, silent gap between consecutive notes of one pattern, in ms (1..255).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `act_sonido` in 1: one-cycle request strobe.
- `data_in` in 8: sound code; sampled only when `act_sonido`=1; `[2:0]` selects the pattern, `[7:3]` are ignored.
- `tone_half_period` out 18: PWM half-period in clk cycles; valid while `tone_en`=1.
- `tone_en` out 1: PWM output enable.
- `busy` out 1: high from the LOAD state until DONE inclusive.
- `done` out 1: one-cycle pulse when a pattern completes (not on abort).

## Operation
- Patterns (frequency Hz / duration ms; "rest" means half-period 0, tone_en=0):
  - code 1 beep: 880/100.
  - code 2 ok: 660/80, 880/80.
  - code 3 error: 220/200, rest/50, 220/200.
  - code 4 score: 523/60, 659/60, 784/60, 1047/120.
  - codes 0, 5, 6, 7: no pattern.
- Half-period = CLK_HZ/(2·f), truncated, 18 bits. At 100 MHz, 880 Hz gives 56818.
- ms tick: prescaler counts 0..CLK_HZ/1000−1 and pulses at the top. The prescaler is cleared on every entry to PLAY or GAP, so a duration of d ms lasts exactly d·CLK_HZ/1000 cycles.
- FSM:
  - IDLE → LOAD on `act_sonido` with code 1–4. Other codes are ignored.
  - LOAD: fetch the note at index idx, latch its half-period and duration → PLAY.
  - PLAY: `tone_en`=1 unless the note is a rest. At the duration end: if last note → DONE, else idx+1 → GAP.
  - GAP: `tone_en`=0 for GAP_MS → LOAD.
  - DONE: `done`=1 for one cycle. → LOAD with the pending code if one is held (clear pending), else → IDLE.
- Requests while not IDLE:
  - code 1–4 overwrites the single pending slot; last one wins.
  - code 0 aborts: → IDLE next cycle, `tone_en`=0, pending cleared, no `done` pulse.
  - codes 5–7 are ignored.
- Request in the same cycle the FSM is in DONE: the new code is captured as pending and that pending value is used.
- Duration 0 in the table is treated as 1 ms.
- `reset` mid-pattern: all outputs are 0 immediately and the FSM is in IDLE.

## Timing
- Reset values: `tone_half_period`=0, `tone_en`=0, `busy`=0, `done`=0, state IDLE, pending empty.
- Latency: `act_sonido` sampled at edge n puts the FSM in LOAD after n. After edge n+1 the FSM is in PLAY, with `tone_en` and `tone_half_period` valid.
- `tone_half_period` holds its last value during GAP and rests. It resets to 0 only on `reset` or abort.
- The `done` cycle is followed either by IDLE (`busy`=0) or by LOAD (`busy` stays 1).
- All outputs are registered.

## Structure
- `audio_pkg`:
  - `state_t` enum (IDLE, LOAD, PLAY, GAP, DONE).
  - Sound code localparams (SND_STOP=0, SND_BEEP=1, SND_OK=2, SND_ERROR=3, SND_SCORE=4).
  - Note frequency constants.
  - `half_period(f)` function computing CLK_HZ/(2f).
- Sub-module `audio_pattern_rom`: combinational. Inputs are code[2:0] and idx[1:0]. Outputs are half_period[17:0], dur_ms[7:0] and last.
- Top module: FSM, prescaler, ms counter, pending register.

## Test plan
Parameters for all scenarios: CLK_HZ=1_000_000, so 1 ms = 1000 cycles.
- **Beep:** reset, then code 1 pulse. Response: `tone_en` high exactly 100000 cycles with half-period 568; `done` one cycle; then `busy`=0.
- **Error pattern:** code 3. Response: 200000 cycles at half-period 2272, 10000 gap, 50000 rest (`tone_en`=0), 10000 gap, 200000 at 2272, then `done`.
- **Pending overwrite:** code 1; at 20 ms code 2; at 30 ms code 4. Response: after the beep `done`, the score pattern starts immediately (first note half-period 956). Code 2 is never played.
- **Abort:** code 4, then code 0 at 70 ms. Response: the next cycle shows IDLE, `tone_en`=0, `tone_half_period`=0, and no `done`; a later code 1 plays normally.
- **Ignored codes:** codes 0, 5 and 7 in IDLE → `busy` stays 0. Codes 6 and 7 sent mid-pattern do not alter the pending slot.
- **Async reset:** `reset` asserted mid-note between clock edges. Response: outputs 0 without waiting for a clock edge; the pending request is lost.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sequencer.
// Provides the FSM state type, sound codes, note frequencies and the
// half-period helper used to build the pattern table.
package audio_pkg;

    localparam int unsigned HP_W  = 18;
    localparam int unsigned DUR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        DONE
    } state_t;

    // Sound codes carried in data_in[2:0]
    localparam logic [2:0] SND_STOP  = 3'd0;
    localparam logic [2:0] SND_BEEP  = 3'd1;
    localparam logic [2:0] SND_OK    = 3'd2;
    localparam logic [2:0] SND_ERROR = 3'd3;
    localparam logic [2:0] SND_SCORE = 3'd4;

    // Note frequencies in Hz; 0 marks a rest
    localparam int unsigned F_REST  = 0;
    localparam int unsigned F_A3    = 220;
    localparam int unsigned F_C5    = 523;
    localparam int unsigned F_E5    = 659;
    localparam int unsigned F_OK_LO = 660;
    localparam int unsigned F_G5    = 784;
    localparam int unsigned F_A5    = 880;
    localparam int unsigned F_C6    = 1047;

    // PWM half-period in clock cycles, truncated; a rest yields 0
    function automatic logic [HP_W-1:0] half_period(input int unsigned clk_hz,
                                                    input int unsigned freq_hz);
        if (freq_hz == 0) begin
            return '0;
        end
        return HP_W'(clk_hz / (2 * freq_hz));
    endfunction

    // Codes that select a stored pattern
    function automatic logic is_pattern(input logic [2:0] code);
        return (code >= SND_BEEP) && (code <= SND_SCORE);
    endfunction

endpackage

// File: rtl/audio_pattern_rom.sv
// Combinational pattern table.
// Ports: code/idx select a note; half_period (0 = rest), dur_ms and last
// describe it. Unknown codes return a zero-length last entry.
module audio_pattern_rom
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic [2:0]       code,
    input  logic [1:0]       idx,
    output logic [HP_W-1:0]  half_period,
    output logic [DUR_W-1:0] dur_ms,
    output logic             last
);

    localparam logic [HP_W-1:0] HP_A3    = audio_pkg::half_period(CLK_HZ, F_A3);
    localparam logic [HP_W-1:0] HP_C5    = audio_pkg::half_period(CLK_HZ, F_C5);
    localparam logic [HP_W-1:0] HP_E5    = audio_pkg::half_period(CLK_HZ, F_E5);
    localparam logic [HP_W-1:0] HP_OK_LO = audio_pkg::half_period(CLK_HZ, F_OK_LO);
    localparam logic [HP_W-1:0] HP_G5    = audio_pkg::half_period(CLK_HZ, F_G5);
    localparam logic [HP_W-1:0] HP_A5    = audio_pkg::half_period(CLK_HZ, F_A5);
    localparam logic [HP_W-1:0] HP_C6    = audio_pkg::half_period(CLK_HZ, F_C6);
    localparam logic [HP_W-1:0] HP_REST  = audio_pkg::half_period(CLK_HZ, F_REST);

    // Note lookup
    always_comb begin
        half_period = '0;
        dur_ms      = '0;
        last        = 1'b1;
        case (code)
            SND_BEEP: begin
                half_period = HP_A5;
                dur_ms      = 8'd100;
            end
            SND_OK: begin
                case (idx)
                    2'd0:    begin half_period = HP_OK_LO; dur_ms = 8'd80; last = 1'b0; end
                    default: begin half_period = HP_A5;    dur_ms = 8'd80; end
                endcase
            end
            SND_ERROR: begin
                case (idx)
                    2'd0:    begin half_period = HP_A3;   dur_ms = 8'd200; last = 1'b0; end
                    2'd1:    begin half_period = HP_REST; dur_ms = 8'd50;  last = 1'b0; end
                    default: begin half_period = HP_A3;   dur_ms = 8'd200; end
                endcase
            end
            SND_SCORE: begin
                case (idx)
                    2'd0:    begin half_period = HP_C5; dur_ms = 8'd60;  last = 1'b0; end
                    2'd1:    begin half_period = HP_E5; dur_ms = 8'd60;  last = 1'b0; end
                    2'd2:    begin half_period = HP_G5; dur_ms = 8'd60;  last = 1'b0; end
                    default: begin half_period = HP_C6; dur_ms = 8'd120; end
                endcase
            end
            default: begin
                half_period = '0;
            end
        endcase
    end

endmodule

// File: rtl/audio_sequencer.sv
// Plays stored note patterns on request and drives the PWM tone generator.
// Ports: clk, reset (async, active-high); act_sonido/data_in request strobe
// and sound code; tone_half_period/tone_en to the PWM; busy while a pattern
// runs; done pulses once per completed pattern. One request can be queued
// while playing; code 0 aborts.
module audio_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned GAP_MS = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            act_sonido,
    input  logic [7:0]      data_in,
    output logic [HP_W-1:0] tone_half_period,
    output logic            tone_en,
    output logic            busy,
    output logic            done
);

    localparam int unsigned     TICKS   = CLK_HZ / 1000;
    localparam int unsigned     PRE_W   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_DUR = DUR_W'(GAP_MS);

    state_t             state;
    logic [2:0]         code_r;
    logic [1:0]         idx;
    logic [PRE_W-1:0]   presc;
    logic [DUR_W-1:0]   ms_cnt;
    logic [DUR_W-1:0]   ms_target;
    logic               last_r;
    logic               pend_valid;
    logic [2:0]         pend_code;

    logic [HP_W-1:0]    rom_hp;
    logic [DUR_W-1:0]   rom_dur;
    logic               rom_last;

    logic [2:0]         req_code;
    logic               req_play;
    logic               req_stop;
    logic               ms_tick;
    logic               interval_end;

    audio_pattern_rom #(.CLK_HZ(CLK_HZ)) u_rom (
        .code        (code_r),
        .idx         (idx),
        .half_period (rom_hp),
        .dur_ms      (rom_dur),
        .last        (rom_last)
    );

    // Request decode; upper code bits carry no meaning
    assign req_code = data_in[2:0];
    assign req_play = act_sonido && is_pattern(req_code);
    assign req_stop = act_sonido && (req_code == SND_STOP);

    // End of the current note or gap: last cycle of the last ms
    assign ms_tick      = (presc == PRE_TOP);
    assign interval_end = ms_tick && (ms_cnt == (ms_target - DUR_W'(1)));

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            code_r           <= SND_STOP;
            idx              <= '0;
            presc            <= '0;
            ms_cnt           <= '0;
            ms_target        <= DUR_W'(1);
            last_r           <= 1'b0;
            pend_valid       <= 1'b0;
            pend_code        <= SND_STOP;
            tone_half_period <= '0;
            tone_en          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (req_play) begin
                    code_r <= req_code;
                    idx    <= '0;
                    busy   <= 1'b1;
                    state  <= LOAD;
                end
            end else if (req_stop) begin
                // Abort: silence and forget everything, no done pulse
                state            <= IDLE;
                tone_en          <= 1'b0;
                tone_half_period <= '0;
                busy             <= 1'b0;
                pend_valid       <= 1'b0;
            end else begin
                if (req_play) begin
                    pend_valid <= 1'b1;
                    pend_code  <= req_code;
                end
                case (state)
                    LOAD: begin
                        // A rest keeps the previous half-period on the output
                        tone_en <= (rom_hp != '0);
                        if (rom_hp != '0) begin
                            tone_half_period <= rom_hp;
                        end
                        ms_target <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                        last_r    <= rom_last;
                        presc     <= '0;
                        ms_cnt    <= '0;
                        state     <= PLAY;
                    end
                    PLAY: begin
                        if (interval_end) begin
                            tone_en <= 1'b0;
                            presc   <= '0;
                            ms_cnt  <= '0;
                            if (last_r) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                idx       <= idx + 2'd1;
                                ms_target <= GAP_DUR;
                                state     <= GAP;
                            end
                        end else if (ms_tick) begin
                            presc  <= '0;
                            ms_cnt <= ms_cnt + DUR_W'(1);
                        end else begin
                            presc <= presc + PRE_W'(1);
                        end
                    end
                    GAP: begin
                        if (interval_end) begin
                            state <= LOAD;
                        end else if (ms_tick) begin
                            presc  <= '0;
                            ms_cnt <= ms_cnt + DUR_W'(1);
                        end else begin
                            presc <= presc + PRE_W'(1);
                        end
                    end
                    DONE: begin
                        // A request arriving now is newer than the held one
                        if (req_play) begin
                            code_r     <= req_code;
                            idx        <= '0;
                            pend_valid <= 1'b0;
                            state      <= LOAD;
                        end else if (pend_valid) begin
                            code_r     <= pend_code;
                            idx        <= '0;
                            pend_valid <= 1'b0;
                            state      <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
